// File: rtl/evt_led_pkg.sv
// Shared definitions for the event LED stretcher: FSM state encoding and default widths.
package evt_led_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  // Default widths: 8-tick pulse, 4-tick gap, queue of up to 15 events
  localparam int unsigned OnWidthDef   = 3;
  localparam int unsigned GapWidthDef  = 2;
  localparam int unsigned PendWidthDef = 4;

endpackage

// File: rtl/ce_tick_timer.sv
// CE-gated up-counter with synchronous clear (priority over counting) and a
// terminal-count flag that is high while the count is all-ones.
module ce_tick_timer
  import evt_led_pkg::*;
#(
  parameter int unsigned WIDTH = OnWidthDef
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: clear wins, otherwise advance on enable
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = &count_q;

endmodule

// File: rtl/evt_led_stretcher.sv
// Event LED stretcher: turns each single-cycle event into a 2^ON_WIDTH CE-tick LED pulse
// followed by a 2^GAP_WIDTH CE-tick dark gap. Events arriving while busy are queued in a
// saturating pending counter; a lost event sets the sticky OVF flag.
// Optional feature macro EVT_LED_RETRIGGER_EN: an event during ON restarts the on-timer
// (extends the pulse) instead of being queued.
module evt_led_stretcher
  import evt_led_pkg::*;
#(
  parameter int unsigned ON_WIDTH   = OnWidthDef,
  parameter int unsigned GAP_WIDTH  = GapWidthDef,
  parameter int unsigned PEND_WIDTH = PendWidthDef
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE,
  input  logic                  EVT_IN,
  output logic                  LED_OUT,
  output logic                  BUSY,
  output logic [PEND_WIDTH-1:0] PEND_CNT,
  output logic                  OVF
);

  logic [1:0]            state_q, state_d;
  logic [PEND_WIDTH-1:0] pend_q, pend_d;
  logic                  ovf_q, ovf_d;
  logic                  led_q;

  logic in_on, in_gap;
  logic start, retrig, evt_queued;
  logic on_tc, gap_tc, on_done, gap_done;

  assign in_on  = (state_q == ON);
  assign in_gap = (state_q == GAP);
  assign start  = (state_q == IDLE) & ((pend_q != '0) | EVT_IN);

`ifdef EVT_LED_RETRIGGER_EN
  assign retrig = in_on & EVT_IN;
`else
  assign retrig = 1'b0;
`endif

  // A retriggering event is absorbed into the running pulse, never queued
  assign evt_queued = EVT_IN & ~retrig;
  assign on_done    = in_on & CE & on_tc & ~retrig;
  assign gap_done   = in_gap & CE & gap_tc;

  // Timers are held at zero outside their own state, so each phase starts from zero
  ce_tick_timer #(
    .WIDTH(ON_WIDTH)
  ) u_on_timer (
    .clk_i(CLK),
    .rst_i(RST),
    .clr_i(~in_on | on_done | retrig),
    .en_i (in_on & CE),
    .tc_o (on_tc)
  );

  ce_tick_timer #(
    .WIDTH(GAP_WIDTH)
  ) u_gap_timer (
    .clk_i(CLK),
    .rst_i(RST),
    .clr_i(~in_gap | gap_done),
    .en_i (in_gap & CE),
    .tc_o (gap_tc)
  );

  // FSM next-state: IDLE -> ON -> GAP -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = ON;
      ON:      if (on_done)  state_d = GAP;
      GAP:     if (gap_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pending queue: +1 per queued event, -1 per pulse start, saturating with sticky overflow
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (evt_queued & ~start) begin
      if (&pend_q) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (~evt_queued & start) begin
      pend_d = pend_q - 1'b1;
    end
  end

  // State, queue and registered LED drive; reset overrides any pulse or gap in progress
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      led_q   <= (state_d == ON);
    end
  end

  assign LED_OUT  = led_q;
  assign BUSY     = (state_q != IDLE) | (pend_q != '0);
  assign PEND_CNT = pend_q;
  assign OVF      = ovf_q;

endmodule
